// File: rtl/dm_pipe.sv
// Parametrised MIPS data memory: valid/ready requests, fixed-latency responses,
// sub-word loads/stores and a clear sweep after reset. Optional macro: DM_MISALIGN_CHECK_EN.
module dm_pipe #(
  parameter int ADDR_W         = 5,
  parameter int LATENCY        = 1,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_type,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        init_done
);

  localparam int DEPTH = 1 << ADDR_W;

  typedef enum logic [1:0] {
    S_INIT,
    S_IDLE,
    S_BUSY
  } state_t;

  localparam state_t RST_STATE = (CLEAR_ON_RESET != 0) ? S_INIT : S_IDLE;

  logic [31:0]       mem_q [DEPTH];
  state_t            state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic [2:0]        lat_q, lat_d;
  logic              init_done_q, init_done_d;
  logic [31:0]       resp_rdata_q, resp_rdata_d;
  logic              resp_err_q, resp_err_d;
  logic [31:0]       pend_rdata_q;
  logic              pend_err_q;

  logic [ADDR_W-1:0] idx;
  logic [1:0]        a10;
  logic              accept;
  logic              type_ok;
  logic              misalign;
  logic              bad;
  logic [31:0]       rd_word;
  logic [31:0]       ld_res;
  logic [3:0]        wr_be;
  logic [31:0]       wr_lanes;
  logic              wr_en;
  logic              unused_addr;

  function automatic logic legal_type(input logic [2:0] t);
    return (t == 3'b000) || t[2];
  endfunction

`ifdef DM_MISALIGN_CHECK_EN
  function automatic logic is_misaligned(input logic [2:0] t, input logic [1:0] a);
    if (t == 3'b000) return a != 2'b00;
    if (t[2:1] == 2'b10) return a[0];
    return 1'b0;
  endfunction
`endif

  function automatic logic [31:0] load_ext(input logic [31:0] w, input logic [2:0] t,
                                           input logic [1:0] a);
    logic [15:0] h;
    logic [7:0]  b;
    h = a[1] ? w[31:16] : w[15:0];
    case (a)
      2'd0:    b = w[7:0];
      2'd1:    b = w[15:8];
      2'd2:    b = w[23:16];
      default: b = w[31:24];
    endcase
    case (t)
      3'b000:  return w;
      3'b100:  return {{16{h[15]}}, h};
      3'b101:  return {16'h0000, h};
      3'b110:  return {{24{b[7]}}, b};
      3'b111:  return {24'h000000, b};
      default: return 32'h0;
    endcase
  endfunction

  function automatic logic [3:0] store_be(input logic [2:0] t, input logic [1:0] a);
    case (t[2:1])
      2'b00:   return 4'b1111;
      2'b10:   return a[1] ? 4'b1100 : 4'b0011;
      default: return 4'b0001 << a;
    endcase
  endfunction

  function automatic logic [31:0] store_lanes(input logic [2:0] t, input logic [31:0] d);
    case (t[2:1])
      2'b00:   return d;
      2'b10:   return {2{d[15:0]}};
      default: return {4{d[7:0]}};
    endcase
  endfunction

  assign idx         = req_addr[ADDR_W+1:2];
  assign a10         = req_addr[1:0];
  assign unused_addr = ^req_addr[31:ADDR_W+2];
  assign type_ok     = legal_type(req_type);
`ifdef DM_MISALIGN_CHECK_EN
  assign misalign    = is_misaligned(req_type, a10);
`else
  assign misalign    = 1'b0;
`endif
  assign bad         = !type_ok || misalign;
  assign accept      = req_valid && req_ready;
  assign rd_word     = mem_q[idx];
  assign ld_res      = (bad || req_we) ? 32'h0 : load_ext(rd_word, req_type, a10);
  assign wr_be       = store_be(req_type, a10);
  assign wr_lanes    = store_lanes(req_type, req_wdata);
  assign wr_en       = accept && req_we && !bad;

  assign req_ready   = (state_q == S_IDLE) && init_done_q;
  assign resp_valid  = (state_q == S_BUSY) && (lat_q == 3'd0);
  assign resp_rdata  = resp_rdata_q;
  assign resp_err    = resp_err_q;
  assign init_done   = init_done_q;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    lat_d        = lat_q;
    init_done_d  = init_done_q;
    resp_rdata_d = resp_rdata_q;
    resp_err_d   = resp_err_q;
    case (state_q)
      S_INIT: begin
        cnt_d = cnt_q + 1'b1;
        if (&cnt_q) begin
          state_d     = S_IDLE;
          init_done_d = 1'b1;
        end
      end
      S_IDLE: begin
        init_done_d = 1'b1;
        if (accept) begin
          state_d = S_BUSY;
          lat_d   = 3'(LATENCY - 1);
          // Single-cycle latency has no countdown, so the result lands directly.
          if (LATENCY == 1) begin
            resp_rdata_d = ld_res;
            resp_err_d   = bad;
          end
        end
      end
      S_BUSY: begin
        if (lat_q == 3'd0) begin
          state_d = S_IDLE;
        end else begin
          lat_d = lat_q - 3'd1;
          if (lat_q == 3'd1) begin
            resp_rdata_d = pend_rdata_q;
            resp_err_d   = pend_err_q;
          end
        end
      end
      default: state_d = RST_STATE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= RST_STATE;
      cnt_q        <= '0;
      lat_q        <= 3'd0;
      init_done_q  <= 1'b0;
      resp_rdata_q <= 32'h0;
      resp_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      lat_q        <= lat_d;
      init_done_q  <= init_done_d;
      resp_rdata_q <= resp_rdata_d;
      resp_err_q   <= resp_err_d;
    end
  end

  // Result is captured at accept and held until the response cycle.
  always_ff @(posedge clk) begin
    if (accept) begin
      pend_rdata_q <= ld_res;
      pend_err_q   <= bad;
    end
  end

  always_ff @(posedge clk) begin
    if (state_q == S_INIT) begin
      mem_q[cnt_q] <= 32'h0;
    end else if (wr_en) begin
      for (int i = 0; i < 4; i++) begin
        if (wr_be[i]) mem_q[idx][8*i +: 8] <= wr_lanes[8*i +: 8];
      end
    end
  end

endmodule

// File: doc/dm_pipe.md
Name: dm_pipe

Overview:
Parametrised data memory for the MIPS datapath. It succeeds the fixed 32-word, divided-clock data memory.
- Configurable depth and read latency.
- Valid/ready request handshake and a response valid strobe.
- Correct signed/unsigned sub-word loads and byte-lane stores.
- Hardware clear sweep after reset.
It sits between the MEM stage and the (future) cache/bus, one access in flight at a time.

Parameters:
ADDR_W, 5, word-index width; DEPTH = 2**ADDR_W words of 32 bits
LATENCY, 1, cycles from request accept to resp_valid; legal range 1..8
CLEAR_ON_RESET, 1, 1 = sweep all words to 0 after reset release; 0 = contents undefined, ready immediately

Ports:
clk  in  1  single clock, all state on rising edge
reset  in  1  asynchronous, active-low reset
req_valid  in  1  request present
req_ready  out  1  block can accept a request this cycle
req_we  in  1  1 = store, 0 = load
req_type  in  3  000 word, 100 half signed, 101 half unsigned, 110 byte signed, 111 byte unsigned; other codes = illegal
req_addr  in  32  byte address
req_wdata  in  32  store data, low-aligned (byte in [7:0], half in [15:0])
resp_valid  out  1  one-cycle strobe: response for the accepted request
resp_rdata  out  32  load result, extended to 32 bits; 0 for stores
resp_err  out  1  qualified by resp_valid: illegal type, or misaligned (macro on)
init_done  out  1  clear sweep finished

Behaviour:
- Reset (reset=0, async): FSM->INIT (or IDLE if CLEAR_ON_RESET=0); sweep counter=0; latency counter=0.
- Output reset values: req_ready=0, resp_valid=0, resp_rdata=0, resp_err=0, init_done=0.
- INIT:
  - Writes 0 to word[cnt], one word per cycle, cnt 0..DEPTH-1; req_ready=0.
  - After word DEPTH-1: ->IDLE, init_done=1 from the next cycle on, held until the next reset.
  - With CLEAR_ON_RESET=0, init_done=1 the first cycle after reset release.
- IDLE:
  - req_ready=1.
  - Accept when req_valid & req_ready: latch we/type/addr/data, ->BUSY, latency counter=LATENCY-1.
- Accepted store: the write commits in the accept cycle.
  - word: all 4 lanes.
  - half: lanes {1,0} if addr[1]=0, else {3,2}.
  - byte: lane addr[1:0].
  - Unwritten lanes are preserved.
- Accepted load: the word is read in the accept cycle.
  - Half lane selected by addr[1]; byte lane by addr[1:0].
  - Signed types sign-extend from bit 15/7; unsigned types zero-extend; word is passed through.
- Word index = addr[ADDR_W+1:2]; upper address bits are ignored (addresses wrap modulo 4*DEPTH).
- BUSY:
  - req_ready=0; counter decrements each cycle.
  - When counter==0: resp_valid=1 for that one cycle with resp_rdata/resp_err, then ->IDLE.
  - With LATENCY=1, resp_valid is asserted the cycle after accept.
  - A new request can be accepted the cycle after resp_valid (throughput = 1 per LATENCY+1 cycles).
- Illegal req_type: no write; resp_rdata=0; resp_err=1.
- Read-after-write: a load accepted after a store's resp_valid sees the stored data.
- resp_rdata holds its last value between strobes; reset clears it.
- Reset mid-INIT or mid-BUSY: abort immediately, no response issued, sweep restarts.
  - A store already accepted has committed.
- req_valid while req_ready=0 is ignored; the requester must hold req_valid.

Optional Feature:
DM_MISALIGN_CHECK_EN
- Defined: half access with addr[0]=1, or word access with addr[1:0]!=0, is misaligned.
  - No write occurs; resp_rdata=0; resp_err=1.
- Undefined: the unused low address bits are ignored (half uses addr[1] only, word uses neither).
  - resp_err is raised only for illegal types.

Test Plan:
- Reset, CLEAR_ON_RESET=1, ADDR_W=5 -> req_ready=0 for 32 cycles after release; init_done rises; load word from any address returns 0x00000000.
- Store word 0x89ABCDEF @0x10, then load 100/101 @0x12 -> 0xFFFF89AB then 0x000089AB; load 110/111 @0x11 -> 0xFFFFFFCD then 0x000000CD.
- Store byte 0x5A @0x23 over word 0x11223344 @0x20, then load word @0x20 -> 0x5A223344.
- LATENCY=3: accept at cycle N -> resp_valid only at N+3; req_ready=0 on N+1..N+3; back-to-back req_valid is held until accepted at N+4.
- Type 011 store @0x0 -> resp_err=1, memory unchanged. With DM_MISALIGN_CHECK_EN, word load @0x2 -> resp_err=1, rdata=0; without it -> word @0x0 returned, resp_err=0.
- Assert reset during BUSY of a load -> no resp_valid; outputs return to reset values; sweep repeats.
